// File: rtl/cmp_rr_arbiter_if.sv
// Requester and result-consumer signals of the shared-comparator arbiter.
// The master side drives requests and consumes results; the slave side is the arbiter.
interface cmp_rr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int W     = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*W-1:0] req_a;
    logic [N_REQ*W-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic               rsp_g;
    logic               rsp_e;
    logic               rsp_l;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_g, rsp_e, rsp_l
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_g, rsp_e, rsp_l
    );
endinterface

// File: rtl/cmp_rr_arbiter.sv
// Round-robin arbiter sharing one unsigned magnitude comparator among N_REQ requesters,
// with a one-entry registered result buffer that can drain and refill in the same cycle.
module cmp_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 4
) (
    input logic              clk,
    input logic              rst_n,
    cmp_rr_arbiter_if.slave  bus
);
    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  winner;
    logic             any_valid;
    logic             can_accept;
    logic             accept;
    logic [N_REQ-1:0] grant;
    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return ID_W'(s);
    endfunction

    // Walk from the farthest slot back to ptr so the first valid bit at or after ptr wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[wrap_add(ptr, k)]) begin
                winner    = wrap_add(ptr, k);
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_a = bus.req_a[i*W +: W];
                sel_b = bus.req_b[i*W +: W];
            end
        end
    end

    // Reset gates acceptance so req_ready drops the moment rst_n falls.
    always_comb begin
        can_accept = rst_n && ((state == EMPTY) || bus.rsp_ready);
        accept     = can_accept && any_valid;
        grant      = '0;
        if (accept) begin
            grant[winner] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (bus.rsp_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            bus.rsp_id <= '0;
            bus.rsp_g  <= 1'b0;
            bus.rsp_e  <= 1'b0;
            bus.rsp_l  <= 1'b0;
        end else if (accept) begin
            ptr        <= wrap_add(winner, 1);
            bus.rsp_id <= winner;
            bus.rsp_g  <= (sel_a > sel_b);
            bus.rsp_e  <= (sel_a == sel_b);
            bus.rsp_l  <= (sel_a < sel_b);
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = (state == FULL);

endmodule
